// File: rtl/onehot_decoder_seq_pkg.sv
// rtl/onehot_decoder_seq_pkg.sv - shared types, defaults and width helpers for the one-hot decoder
package onehot_dec_pkg;

   typedef enum logic {IDLE, DRIVE} state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_HOLD  = 2;

   function automatic int code_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// rtl/onehot_decoder_seq_if.sv - code handshake and one-hot output bundle
interface onehot_decoder_seq_if
   import onehot_dec_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) ();
   localparam int CODE_W = code_w(WIDTH);
   localparam int CNT_W  = count_w(DEPTH);

   logic [CODE_W-1:0] code_in;
   logic              code_valid;
   logic              code_ready;
   logic [WIDTH-1:0]  onehot;
   logic              onehot_valid;
   logic [CNT_W-1:0]  fifo_count;
   logic              range_err;

   modport master (
      output code_in, code_valid,
      input  code_ready, onehot, onehot_valid, fifo_count, range_err
   );

   modport slave (
      input  code_in, code_valid,
      output code_ready, onehot, onehot_valid, fifo_count, range_err
   );
endinterface

// File: rtl/onehot_decoder_seq_code_fifo.sv
// rtl/onehot_decoder_seq_code_fifo.sv - synchronous code FIFO with registered occupancy count
module code_fifo
   import onehot_dec_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CODE_W = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [CODE_W-1:0]         push_data,
   input  logic                      pop,
   output logic [CODE_W-1:0]         pop_data,
   output logic                      full,
   output logic                      empty,
   output logic [count_w(DEPTH)-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_w(DEPTH);

   logic [CODE_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   // Full comes from the registered count, so a pop never frees a slot for a same-edge push.
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end
endmodule

// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - buffered code-to-one-hot decoder holding each word for HOLD cycles
module onehot_decoder_seq
   import onehot_dec_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int HOLD  = DEF_HOLD
) (
   input  logic                clk,
   input  logic                rst,
   onehot_decoder_seq_if.slave bus
);
   localparam int CODE_W = code_w(WIDTH);
   localparam int CNT_W  = count_w(DEPTH);
   localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

   state_t            state;
   logic [HOLD_W-1:0] cnt;
   logic              full;
   logic              empty;
   logic              pop;
   logic [CODE_W-1:0] head;
   logic [CNT_W-1:0]  count;
   logic              head_oor;
   logic [WIDTH-1:0]  head_word;

   // A new word is taken whenever the current one has run its last cycle (or nothing is active).
   assign pop       = !empty && ((state == IDLE) || (cnt == '0));
   assign head_oor  = (int'(head) >= WIDTH);
   assign head_word = head_oor ? '0 : ({{(WIDTH-1){1'b0}}, 1'b1} << head);

   assign bus.code_ready = !full;
   assign bus.fifo_count = count;

   code_fifo #(
      .DEPTH  (DEPTH),
      .CODE_W (CODE_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.code_valid),
      .push_data (bus.code_in),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= '0;
         bus.onehot       <= '0;
         bus.onehot_valid <= 1'b0;
         bus.range_err    <= 1'b0;
      end else begin
         if (pop && head_oor) begin
            bus.range_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (pop) begin
                  bus.onehot       <= head_word;
                  bus.onehot_valid <= 1'b1;
                  cnt              <= HOLD_LAST;
                  state            <= DRIVE;
               end
            end
            DRIVE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (pop) begin
                  bus.onehot <= head_word;
                  cnt        <= HOLD_LAST;
               end else begin
                  bus.onehot       <= '0;
                  bus.onehot_valid <= 1'b0;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
